// File: rtl/state_machine_pkg.sv
// Shared types and constants for the run-length qualification FSM.
// Optional feature macro: STATE_MACHINE_SYNC_EN (adds a 2-flop input synchronizer).
package state_machine_pkg;

    localparam int STATE_W = 2;

    // The state code is also the reported run length, so out_o can be the state register itself.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        ONE  = 2'b01,
        TWO  = 2'b10,
        SAT  = 2'b11
    } state_e;

endpackage

// File: rtl/state_machine_sync.sv
// Two-flop synchronizer for the serial input sample.
// Used by state_machine only when STATE_MACHINE_SYNC_EN is defined.
module state_machine_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic in_i,
    output logic out_o
);

    logic [1:0] sync_q;

    // Shift the raw sample through two flops; both clear to 0 on reset so the FSM sees a low input.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], in_i};
        end
    end

    assign out_o = sync_q[1];

endmodule

// File: rtl/state_machine.sv
// Moore FSM counting consecutive high samples on in_i, saturating at 3.
// DECAY_MODE selects reset-to-idle or step-down on a low sample.
// SAT_HOLD makes the saturated state sticky until reset.
// Optional feature macro: STATE_MACHINE_SYNC_EN (in_i passes through a
// 2-flop synchronizer, raising latency from 1 to 3 cycles).
module state_machine
    import state_machine_pkg::*;
#(
    parameter int unsigned DECAY_MODE = 0,
    parameter int unsigned SAT_HOLD   = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               in_i,
    output logic [STATE_W-1:0] out_o
);

    logic   fsm_in;
    state_e state_q;

`ifdef STATE_MACHINE_SYNC_EN
    state_machine_sync u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .in_i    (in_i),
        .out_o   (fsm_in)
    );
`else
    assign fsm_in = in_i;
`endif

    // Advance the run length on a high sample; on a low sample fall to IDLE or step down one
    // state depending on DECAY_MODE, with SAT optionally held until reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: state_q <= fsm_in ? ONE : IDLE;
                ONE:  state_q <= fsm_in ? TWO : IDLE;
                TWO: begin
                    if (fsm_in) begin
                        state_q <= SAT;
                    end else if (DECAY_MODE != 0) begin
                        state_q <= ONE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SAT: begin
                    if (fsm_in || (SAT_HOLD != 0)) begin
                        state_q <= SAT;
                    end else if (DECAY_MODE != 0) begin
                        state_q <= TWO;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_o = state_q;

endmodule

// File: tb/tb_state_machine.sv
// Self-checking bench for state_machine: three instances cover the default,
// step-down (DECAY_MODE=1) and sticky-saturation (SAT_HOLD=1) variants.
// Expected codes come from a vector table and flow through a scoreboard queue.
module tb_state_machine;

`ifdef STATE_MACHINE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        string      name;
        bit         rst_before;
        logic       in;
        logic [1:0] exp_def;
        logic [1:0] exp_dec;
        logic [1:0] exp_hold;
    } vec_t;

    typedef struct {
        int         due;
        string      name;
        logic [1:0] exp_def;
        logic [1:0] exp_dec;
        logic [1:0] exp_hold;
    } sb_t;

    logic       clk_i;
    logic       reset_i;
    logic       in_i;
    logic [1:0] out_def;
    logic [1:0] out_dec;
    logic [1:0] out_hold;

    vec_t vecs[$];
    sb_t  sb[$];
    int   cycle;
    int   checks;
    int   failures;

    state_machine #(.DECAY_MODE(0), .SAT_HOLD(0)) u_def (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .in_i    (in_i),
        .out_o   (out_def)
    );

    state_machine #(.DECAY_MODE(1), .SAT_HOLD(0)) u_dec (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .in_i    (in_i),
        .out_o   (out_dec)
    );

    state_machine #(.DECAY_MODE(0), .SAT_HOLD(1)) u_hold (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .in_i    (in_i),
        .out_o   (out_hold)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string name, input logic [1:0] e_def, input logic [1:0] e_dec,
                            input logic [1:0] e_hold);
        checkOutput({name, "/def"}, out_def, e_def);
        checkOutput({name, "/dec"}, out_dec, e_dec);
        checkOutput({name, "/hold"}, out_hold, e_hold);
    endtask

    task automatic addVec(input string name, input bit rst_before, input logic in,
                          input logic [1:0] e_def, input logic [1:0] e_dec, input logic [1:0] e_hold);
        vec_t v;
        v.name       = name;
        v.rst_before = rst_before;
        v.in         = in;
        v.exp_def    = e_def;
        v.exp_dec    = e_dec;
        v.exp_hold   = e_hold;
        vecs.push_back(v);
    endtask

    // Drive one sample on the falling edge, optionally queue its expectation, then retire
    // every queued expectation that falls due at this rising edge.
    task automatic applyStimulus(input logic v, input bit push, input string name,
                                 input logic [1:0] e_def, input logic [1:0] e_dec, input logic [1:0] e_hold);
        sb_t e;
        @(negedge clk_i);
        in_i = v;
        if (push) begin
            e.due      = cycle + LAT;
            e.name     = name;
            e.exp_def  = e_def;
            e.exp_dec  = e_dec;
            e.exp_hold = e_hold;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        cycle++;
        while (sb.size() > 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            checkAll(e.name, e.exp_def, e.exp_dec, e.exp_hold);
        end
    endtask

    // Hold the input steady until every pending expectation has been compared.
    task automatic drainScoreboard();
        int n = 0;
        while (sb.size() > 0 && n < 10) begin
            applyStimulus(in_i, 1'b0, "", 2'b00, 2'b00, 2'b00);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d entries left, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Reset for two cycles, with in_i high on the second to show it is ignored.
    task automatic resetPulse(input string name);
        @(negedge clk_i);
        reset_i = 1'b1;
        in_i    = 1'b0;
        #1;
        checkAll({name, "_immediate"}, 2'b00, 2'b00, 2'b00);
        @(negedge clk_i);
        checkAll({name, "_hold1"}, 2'b00, 2'b00, 2'b00);
        in_i = 1'b1;
        @(negedge clk_i);
        checkAll({name, "_hold2"}, 2'b00, 2'b00, 2'b00);
        in_i    = 1'b0;
        reset_i = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cycle    = 0;
        reset_i  = 1'b1;
        in_i     = 1'b0;

        // Saturation, then drop: default clears, decay steps down, hold stays at SAT.
        addVec("s1_low0",  1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        addVec("s1_low1",  1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        addVec("s1_hi1",   1'b0, 1'b1, 2'b01, 2'b01, 2'b01);
        addVec("s1_hi2",   1'b0, 1'b1, 2'b10, 2'b10, 2'b10);
        addVec("s1_hi3",   1'b0, 1'b1, 2'b11, 2'b11, 2'b11);
        addVec("s1_hi4",   1'b0, 1'b1, 2'b11, 2'b11, 2'b11);
        addVec("s1_hi5",   1'b0, 1'b1, 2'b11, 2'b11, 2'b11);
        addVec("s1_drop1", 1'b0, 1'b0, 2'b00, 2'b10, 2'b11);
        addVec("s1_drop2", 1'b0, 1'b0, 2'b00, 2'b01, 2'b11);
        addVec("s1_drop3", 1'b0, 1'b0, 2'b00, 2'b00, 2'b11);
        addVec("s1_drop4", 1'b0, 1'b0, 2'b00, 2'b00, 2'b11);
        // Mixed pattern below saturation and around it.
        addVec("s2_a", 1'b1, 1'b1, 2'b01, 2'b01, 2'b01);
        addVec("s2_b", 1'b0, 1'b1, 2'b10, 2'b10, 2'b10);
        addVec("s2_c", 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);
        addVec("s2_d", 1'b0, 1'b1, 2'b01, 2'b10, 2'b01);
        addVec("s2_e", 1'b0, 1'b1, 2'b10, 2'b11, 2'b10);
        addVec("s2_f", 1'b0, 1'b0, 2'b00, 2'b10, 2'b00);
        addVec("s2_g", 1'b0, 1'b1, 2'b01, 2'b11, 2'b01);
        addVec("s2_h", 1'b0, 1'b0, 2'b00, 2'b10, 2'b00);
        addVec("s2_i", 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) begin
                drainScoreboard();
                resetPulse({"rst_before_", vecs[i].name});
            end
            applyStimulus(vecs[i].in, 1'b1, vecs[i].name,
                          vecs[i].exp_def, vecs[i].exp_dec, vecs[i].exp_hold);
        end
        drainScoreboard();

        // Async reset mid-run: reach ONE, then assert reset between edges and expect 00 at once.
        resetPulse("async_setup");
        applyStimulus(1'b1, 1'b1, "async_pre", 2'b01, 2'b01, 2'b01);
        drainScoreboard();
        @(negedge clk_i);
        in_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        checkAll("async_mid", 2'b00, 2'b00, 2'b00);
        @(negedge clk_i);
        reset_i = 1'b0;

        // First high sample from IDLE must show up exactly LAT rising edges later.
        @(negedge clk_i);
        in_i = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            @(posedge clk_i);
            #1;
            checkOutput($sformatf("latency_edge%0d", e), out_def, (e == LAT) ? 2'b01 : 2'b00);
        end
        in_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #20000;
        $display("[TB] FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/state_machine.md
Name: state_machine

Overview:
- Small Moore FSM that tracks consecutive high samples on a 1-bit serial input `in_i`.
- Reports the saturating run length (0..3) on a 2-bit output.
- Used as a simple input-activity/qualification stage.
- One clock domain; all state updates on the rising edge of `clk_i`.

Parameters:
- DECAY_MODE, default 0: 0 = a low sample returns the FSM to IDLE; 1 = a low sample steps down one state.
- SAT_HOLD, default 0: 0 = SAT is left on a low sample like any other state; 1 = SAT is sticky until reset.

Ports:
- clk_i  input  1  system clock; rising-edge active
- reset_i  input  1  asynchronous, active-high reset
- in_i  input  1  serial input sample, evaluated every rising edge
- out_o  output  2  current run-length state code (Moore, registered)

Behaviour:
- One clock; reset is asynchronous and active-high. Clock port is `clk_i`, reset port is `reset_i`.
- States and codes (`out_o` equals the state code):
  - IDLE = 2'b00
  - ONE = 2'b01
  - TWO = 2'b10
  - SAT = 2'b11
- Reset:
  - `reset_i`=1 forces state IDLE and `out_o`=2'b00 immediately, without waiting for a clock edge.
  - Held while `reset_i`=1; `in_i` is ignored during reset.
  - On deassertion, the first rising edge with `reset_i`=0 evaluates `in_i` normally.
- Transitions on `in_i`=1: IDLE->ONE, ONE->TWO, TWO->SAT, SAT->SAT (saturates, no wrap to 00).
- Transitions on `in_i`=0:
  - DECAY_MODE=0: any state -> IDLE.
  - DECAY_MODE=1: SAT->TWO, TWO->ONE, ONE->IDLE, IDLE->IDLE.
  - SAT_HOLD=1: SAT stays SAT regardless of `in_i` until reset.
- Latency: `out_o` reflects `in_i` sampled at the previous rising edge, i.e. 1 cycle.
- Output timing: `out_o` is driven directly from the state register; no combinational path from `in_i` to `out_o`.
- Reset mid-run: async reset wins over any pending transition; the next state after release is computed from IDLE.
- Illegal/unreachable encodings: none exist with 2 bits. The default branch of the next-state logic still targets IDLE.

Optional Feature:
- Macro: STATE_MACHINE_SYNC_EN.
- When defined:
  - `in_i` passes through a 2-flop synchronizer before the FSM; latency becomes 3 cycles.
  - Synchronizer flops reset asynchronously to 0.
- When undefined: `in_i` feeds the FSM directly; latency 1 cycle.

Decomposition:
- Package `state_machine_pkg`:
  - `state_e` enum (IDLE, ONE, TWO, SAT) with 2-bit encodings as above.
  - Constant `STATE_W`=2.
- Sub-module `state_machine_sync`: 2-flop async-reset synchronizer, instantiated only under STATE_MACHINE_SYNC_EN.
- Next-state logic, state register and output assignment stay in `state_machine`.

Test Plan:
- Reset hold: `reset_i`=1, `in_i`=0 for 2 cycles -> `out_o`=00 throughout.
- Single step: release reset, `in_i`=0 for 2 cycles -> `out_o`=00; then `in_i`=1 set on a falling edge -> `out_o`=01 after the next rising edge.
- Async reset mid-run: from ONE, assert `reset_i` between clock edges with `in_i`=0 -> `out_o`=00 immediately, before the next rising edge.
- Saturation: `in_i`=1 for 5 cycles from IDLE -> `out_o` 01, 10, 11, 11, 11.
- Drop, DECAY_MODE=0: from SAT, `in_i`=0 for 1 cycle -> `out_o`=00.
- Drop, DECAY_MODE=1: from SAT, `in_i`=0 for 3 cycles -> `out_o` 10, 01, 00.
- Sticky SAT (SAT_HOLD=1): reach SAT, then `in_i`=0 for 4 cycles -> `out_o` stays 11 until reset, then 00.
- STATE_MACHINE_SYNC_EN: `in_i`=1 from IDLE -> first `out_o`=01 appears 3 rising edges later.
